// File: rtl/uart_tx_serializer_if.sv
// Parallel-side handshake and serial outputs of the UART frame serializer.
// The master drives the byte request; the slave (serializer) drives the line.
interface uart_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_Data;
  logic                  Data_valid;
  logic                  Par_en;
  logic                  Par_bit;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_Data,
    output Data_valid,
    output Par_en,
    output Par_bit,
    input  TX_OUT,
    input  Busy
  );

  modport slave (
    input  P_Data,
    input  Data_valid,
    input  Par_en,
    input  Par_bit,
    output TX_OUT,
    output Busy
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART frame builder: start bit, LSB-first data, optional parity, stop bit,
// one bit per CLK. TX_OUT and Busy are registered from the next-state decode.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_tx_serializer_if.slave  bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_next;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  r_tx;
  logic                  r_busy;
  logic                  w_accept;
  logic                  w_tx_next;
  logic                  w_busy_next;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.Data_valid) begin
          w_accept     = 1'b1;
          w_cnt_next   = '0;
          w_state_next = S_START;
        end
      end
      S_START: begin
        w_state_next = S_DATA;
      end
      S_DATA: begin
        // Counter parks on the last index instead of wrapping.
        if (r_cnt == LAST_BIT) begin
          w_state_next = r_par_en ? S_PARITY : S_STOP;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_PARITY: begin
        w_state_next = S_STOP;
      end
      S_STOP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Line value for the bit period that begins at the coming edge.
  always_comb begin
    w_tx_next   = 1'b1;
    w_busy_next = 1'b1;
    unique case (w_state_next)
      S_IDLE:   w_busy_next = 1'b0;
      S_START:  w_tx_next   = 1'b0;
      S_DATA:   w_tx_next   = r_data[w_cnt_next];
      S_PARITY: w_tx_next   = r_par_bit;
      S_STOP:   w_tx_next   = 1'b1;
      default:  w_busy_next = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt     <= '0;
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_tx   <= w_tx_next;
      r_busy <= w_busy_next;
      if (w_accept) begin
        r_data    <= bus.P_Data;
        r_par_en  <= bus.Par_en;
        r_par_bit <= bus.Par_bit;
      end
    end
  end

  assign bus.TX_OUT = r_tx;
  assign bus.Busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: queue-based frame model compared every cycle, plus
// literal frame patterns for the directed cases and a randomized soak.
module tb_uart_tx_serializer;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_serializer_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_serializer #(.DATA_WIDTH(DW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is a list of line bits; the line shows the queue head each
  // cycle, and a new request is taken only when the line was idle last cycle.
  bit   mq[$];
  logic exp_tx   = 1'b1;
  logic exp_busy = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end else begin
      if (!exp_busy && bus.Data_valid === 1'b1) begin
        mq.push_back(1'b0);
        for (int i = 0; i < DW; i++) mq.push_back(bus.P_Data[i]);
        if (bus.Par_en) mq.push_back(bus.Par_bit);
        mq.push_back(1'b1);
      end
      if (mq.size() > 0) begin
        exp_tx   = mq.pop_front();
        exp_busy = 1'b1;
      end else begin
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("model_tx", {31'b0, bus.TX_OUT}, {31'b0, exp_tx});
    check("model_busy", {31'b0, bus.Busy}, {31'b0, exp_busy});
  end

  // mode 0: plain pulse; 1: corrupt inputs mid-frame; 2: request while busy;
  // 3: hold Data_valid across two frames (second byte 0x33).
  task automatic run_frame(input logic [7:0] data, input logic pe, input logic pb,
                           input int n, input int mode,
                           output logic [31:0] txs, output logic [31:0] busys);
    bus.P_Data     = data;
    bus.Par_en     = pe;
    bus.Par_bit    = pb;
    bus.Data_valid = 1'b1;
    @(posedge clk);
    #1;
    if (mode != 3) bus.Data_valid = 1'b0;
    else bus.P_Data = 8'h33;
    txs   = '0;
    busys = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      txs   = {txs[30:0], bus.TX_OUT};
      busys = {busys[30:0], bus.Busy};
      if (mode == 1 && i == 3) begin
        bus.P_Data  = ~bus.P_Data;
        bus.Par_bit = ~bus.Par_bit;
      end
      if (mode == 2 && i == 3) begin
        bus.Data_valid = 1'b1;
        bus.P_Data     = 8'hFF;
      end
      if (mode == 2 && i == 7) bus.Data_valid = 1'b0;
      if (mode == 3 && i == 12) bus.Data_valid = 1'b0;
    end
  endtask

  logic [31:0] txs;
  logic [31:0] busys;

  initial begin
    bus.P_Data     = '0;
    bus.Data_valid = 1'b0;
    bus.Par_en     = 1'b0;
    bus.Par_bit    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'b0, bus.TX_OUT}, 32'd1);
    check("reset_busy", {31'b0, bus.Busy}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(8'hA5, 1'b0, 1'b0, 12, 0, txs, busys);
    check("a5_nopar_tx", txs, 32'(12'b0101001011_11));
    check("a5_nopar_busy", busys, 32'(12'b1111111111_00));
    $display("frame A5 no parity: tx=%b busy=%b", txs[11:0], busys[11:0]);

    run_frame(8'hA5, 1'b1, 1'b0, 13, 0, txs, busys);
    check("a5_even_tx", txs, 32'(13'b01010010101_11));
    check("a5_even_busy", busys, 32'(13'b11111111111_00));
    $display("frame A5 parity 0: tx=%b busy=%b", txs[12:0], busys[12:0]);

    run_frame(8'h07, 1'b1, 1'b0, 13, 1, txs, busys);
    check("07_toggle_tx", txs, 32'(13'b01110000001_11));
    $display("frame 07 parity 0 with mid-frame input changes: tx=%b", txs[12:0]);

    run_frame(8'h00, 1'b0, 1'b0, 14, 2, txs, busys);
    check("busy_reject_tx", txs, 32'(14'b0000000001_1111));
    check("busy_reject_busy", busys, 32'(14'b1111111111_0000));
    $display("frame 00 with ignored FF request: tx=%b busy=%b", txs[13:0], busys[13:0]);

    run_frame(8'h55, 1'b0, 1'b0, 22, 3, txs, busys);
    check("b2b_tx", txs, 32'(22'b0101010101_1_0110011001_1));
    check("b2b_busy", busys, 32'(22'b1111111111_0_1111111111_0));
    $display("back-to-back 55/33: tx=%b busy=%b", txs[21:0], busys[21:0]);

    // Asynchronous reset while a 0 data bit is on the line.
    bus.P_Data     = 8'hA5;
    bus.Par_en     = 1'b0;
    bus.Data_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.Data_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_tx", {31'b0, bus.TX_OUT}, 32'd0);
    #2;
    rst = 1'b1;
    bus.Data_valid = 1'b1;
    #1;
    check("async_reset_tx", {31'b0, bus.TX_OUT}, 32'd1);
    check("async_reset_busy", {31'b0, bus.Busy}, 32'd0);
    repeat (2) @(negedge clk);
    check("reset_with_valid_busy", {31'b0, bus.Busy}, 32'd0);
    rst = 1'b0;
    bus.Data_valid = 1'b0;
    txs   = '0;
    busys = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      txs   = {txs[30:0], bus.TX_OUT};
      busys = {busys[30:0], bus.Busy};
    end
    check("post_reset_idle_tx", txs, 32'h0000_0FFF);
    check("post_reset_idle_busy", busys, 32'd0);
    $display("reset mid-frame: post-release tx=%b busy=%b", txs[11:0], busys[11:0]);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst            = ($urandom_range(0, 299) == 0);
      bus.Data_valid = ($urandom_range(0, 3) == 0);
      bus.P_Data     = 8'($urandom);
      bus.Par_en     = 1'($urandom);
      bus.Par_bit    = 1'($urandom);
    end
    @(negedge clk);
    rst            = 1'b0;
    bus.Data_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("final_idle_busy", {31'b0, bus.Busy}, 32'd0);
    $display("random soak: 3000 cycles of randomized requests");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Frame builder and serializer for the UART transmitter. Accepts a parallel byte plus the parity bit produced by the combinational parity calculator in the same cycle. Emits one start bit, data LSB first, an optional parity bit and one stop bit on a registered serial line, one bit per clock. `CLK` is the bit-rate clock; baud generation is outside this block.

## Interface
Parameters:
- `DATA_WIDTH`, 8, number of data bits per frame (≥2).

Ports:
- `CLK`, input, 1, bit-rate clock; all state updates on rising edge.
- `RST`, input, 1, reset, asynchronous and active-high.
- `P_Data`, input, DATA_WIDTH, parallel data; sampled only on accept.
- `Data_valid`, input, 1, request to send `P_Data`; honoured only in IDLE.
- `Par_en`, input, 1, 1 = frame carries a parity bit; sampled on accept.
- `Par_bit`, input, 1, parity bit from the parity calculator, valid in the same cycle as `Data_valid`; sampled on accept.
- `TX_OUT`, output, 1, registered serial line; idle/stop = 1, start = 0.
- `Busy`, output, 1, registered; 1 while a frame is in progress.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Accept: in IDLE with `Data_valid`=1 at a rising edge:
  - latch `P_Data` into the shift register;
  - latch `Par_en` and `Par_bit`;
  - clear the bit counter;
  - go to START.
- `Data_valid` in any state other than IDLE is ignored. No queuing; latched data is unaffected.
- START: `TX_OUT`=0 for one cycle, then DATA.
- DATA: `TX_OUT`= latched bit[counter], starting at bit 0 (LSB first). The counter increments each cycle.
  - After bit DATA_WIDTH-1: go to PARITY if the latched `Par_en`=1, else STOP.
  - The counter is $clog2(DATA_WIDTH) bits wide. It is compared against DATA_WIDTH-1 and never wraps mid-frame.
- PARITY: `TX_OUT`= latched `Par_bit` for one cycle, then STOP.
- STOP: `TX_OUT`=1 for one cycle, then IDLE.
- IDLE: `TX_OUT`=1, `Busy`=0.
- `Busy`=1 in START, DATA, PARITY and STOP.
- Parity is not computed here. The latched `Par_bit` is transmitted verbatim.
- Changes to `P_Data`, `Par_en` or `Par_bit` after accept have no effect on the frame in flight.

## Timing
- Reset (async, any time, including mid-frame): state = IDLE, `TX_OUT`=1, `Busy`=0, counter = 0, shift/latch registers = 0.
  - Release resumes in IDLE.
  - A frame interrupted by reset is abandoned, never resumed.
- Accept at edge k. The following table-free sequence holds:
  - cycle after k: `TX_OUT`=0 and `Busy`=1.
  - cycles k+2 .. k+1+DATA_WIDTH: data bits.
  - next cycle: parity bit, if enabled.
  - next cycle: stop.
  - at the following edge: `Busy`=0 and `TX_OUT` stays 1.
- Frame length: DATA_WIDTH+2 cycles without parity, DATA_WIDTH+3 with parity (10/11 at default).
- Both outputs are registers with no combinational path from inputs.
- Held `Data_valid`: re-accepted at the first IDLE edge.
  - Minimum line-high time between frames is 2 cycles (STOP plus one IDLE).
  - Back-to-back frame period is 11 cycles without parity, 12 with parity.
- A one-cycle `Data_valid` pulse in IDLE is sufficient to start a frame.
- `Data_valid` and `RST` asserted together: reset wins; no frame starts.

## Test plan
- Reset: assert `RST` mid-DATA of a frame. Required: `TX_OUT`=1 and `Busy`=0 immediately (asynchronous). After release, the line stays idle with no residual bits.
- No parity: `P_Data`=0xA5, `Par_en`=0, one-cycle `Data_valid`. Required: `TX_OUT` = 0,1,0,1,0,0,1,0,1,1 over 10 cycles; `Busy` high for exactly 10 cycles.
- Even parity: `P_Data`=0xA5, `Par_en`=1, `Par_bit`=0. Required: 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles.
- Odd parity: `P_Data`=0x07, `Par_bit`=0 (odd parity of 0x07, three ones).
  - Required: 0,1,1,1,0,0,0,0,0,0,1.
  - Also toggle `P_Data`/`Par_bit` mid-frame; the serial output must be unchanged.
- Busy rejection: assert `Data_valid` with 0xFF during DATA of a 0x00 frame, then deassert before IDLE. Required: only the 0x00 frame is sent; no second frame.
- Back-to-back: hold `Data_valid`=1 with 0x55 and then 0x33. Required: two consecutive frames separated by exactly 2 high cycles (stop plus idle).
